// File: rtl/fetch_realigner_if.sv
// IF-stage fetch port plus word-addressed ICACHE port of the fetch realigner.
// The realigner uses the slave modport; the fetch/cache environment uses master.
interface fetch_realigner_if;
  logic [31:0] pc;
  logic        stall;
  logic        redirect;
  logic        ready;
  logic        compressed;
  logic [31:0] inst;
  logic        ICACHE_stall;
  logic        ICACHE_ren;
  logic        ICACHE_wen;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_rdata;
  logic [31:0] ICACHE_wdata;

  modport master (
    output pc, stall, redirect, ICACHE_stall, ICACHE_rdata,
    input  ready, compressed, inst, ICACHE_ren, ICACHE_wen, ICACHE_addr, ICACHE_wdata
  );

  modport slave (
    input  pc, stall, redirect, ICACHE_stall, ICACHE_rdata,
    output ready, compressed, inst, ICACHE_ren, ICACHE_wen, ICACHE_addr, ICACHE_wdata
  );
endinterface

// File: rtl/fetch_realigner.sv
// Realigns halfword-aligned IF PCs onto word ICACHE reads through a one-word line buffer.
// REALIGN_RVC_EN enables RVC and straddling 32-bit fetches; otherwise pc[1] is ignored.
module fetch_realigner #(
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic clk,
  input  logic rst_n,
  fetch_realigner_if.slave bus
);
  localparam logic [1:0] S_LO    = 2'd0;
  localparam logic [1:0] S_HI    = 2'd1;
  localparam logic [1:0] S_RDY   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]  state, state_n;
  logic        buf_v;
  logic [29:0] buf_tag, buf_tag_n;
  logic [31:0] buf_data, buf_data_n;
  logic        buf_ld;
  logic [29:0] drain_addr;
  logic        drain_ld;

  logic [29:0] w0;
  logic        pc1, lo_hit, lo_fill, is_rvc, straddle;
  logic [31:0] lo_word;
  logic [15:0] half;
  logic        unused_pc0;

  assign unused_pc0 = bus.pc[0];
  assign w0         = bus.pc[31:2];
  assign lo_hit     = buf_v && (buf_tag == w0);
  assign lo_word    = lo_hit ? buf_data : bus.ICACHE_rdata;

`ifdef REALIGN_RVC_EN
  logic [29:0] w1;
  logic [31:0] hi_r;
  logic        hi_ld;
  assign w1       = w0 + 30'd1;
  assign pc1      = bus.pc[1];
  assign half     = pc1 ? lo_word[31:16] : lo_word[15:0];
  assign is_rvc   = (half[1:0] != 2'b11);
  assign straddle = pc1 && !is_rvc;
`else
  logic unused_pc1;
  assign unused_pc1 = bus.pc[1];
  assign pc1      = 1'b0;
  assign half     = lo_word[15:0];
  assign is_rvc   = 1'b0;
  assign straddle = 1'b0;
`endif

  assign bus.ICACHE_wen   = 1'b0;
  assign bus.ICACHE_wdata = 32'd0;

  always_comb begin
    state_n         = state;
    bus.ICACHE_ren  = 1'b0;
    bus.ICACHE_addr = w0;
    bus.ready       = 1'b0;
    bus.inst        = NOP_INST;
    bus.compressed  = 1'b0;
    lo_fill         = 1'b0;
    buf_ld          = 1'b0;
    buf_tag_n       = w0;
    buf_data_n      = bus.ICACHE_rdata;
    drain_ld        = 1'b0;
`ifdef REALIGN_RVC_EN
    hi_ld           = 1'b0;
`endif
    case (state)
      S_LO: begin
        bus.ICACHE_ren = !lo_hit;
        if (!lo_hit && !bus.ICACHE_stall) begin
          lo_fill = 1'b1;
          buf_ld  = 1'b1;
        end
        if (lo_hit || lo_fill) begin
          if (!straddle) begin
            bus.ready      = 1'b1;
            bus.inst       = (pc1 || is_rvc) ? {16'd0, half} : lo_word;
            bus.compressed = is_rvc;
          end else begin
            state_n = S_HI;
          end
        end
      end
`ifdef REALIGN_RVC_EN
      S_HI: begin
        bus.ICACHE_ren  = 1'b1;
        bus.ICACHE_addr = w1;
        if (!bus.ICACHE_stall) begin
          bus.ready = 1'b1;
          bus.inst  = {bus.ICACHE_rdata[15:0], buf_data[31:16]};
          if (!bus.stall) begin
            buf_ld    = 1'b1;
            buf_tag_n = w1;
            state_n   = S_LO;
          end else begin
            hi_ld   = 1'b1;
            state_n = S_RDY;
          end
        end
      end
      S_RDY: begin
        bus.ready = 1'b1;
        bus.inst  = {hi_r[15:0], buf_data[31:16]};
        if (!bus.stall) begin
          buf_ld     = 1'b1;
          buf_tag_n  = w1;
          buf_data_n = hi_r;
          state_n    = S_LO;
        end
      end
`endif
      S_DRAIN: begin
        bus.ICACHE_ren  = 1'b1;
        bus.ICACHE_addr = drain_addr;
        if (!bus.ICACHE_stall) state_n = S_LO;
      end
      default: state_n = S_LO;
    endcase

    // A redirect in S_DRAIN needs no action: the next tag compare uses the new pc.
    if (bus.redirect && state != S_DRAIN) begin
      bus.ready      = 1'b0;
      bus.inst       = NOP_INST;
      bus.compressed = 1'b0;
`ifdef REALIGN_RVC_EN
      hi_ld = 1'b0;
      if (state == S_RDY) buf_ld = 1'b0;
      if (state == S_HI && !bus.ICACHE_stall) begin
        buf_ld    = 1'b1;
        buf_tag_n = w1;
      end
`endif
      if (bus.ICACHE_ren && bus.ICACHE_stall) begin
        drain_ld = 1'b1;
        state_n  = S_DRAIN;
      end else begin
        state_n = S_LO;
      end
    end

    if (!rst_n) begin
      bus.ICACHE_ren = 1'b0;
      bus.ready      = 1'b0;
      bus.inst       = NOP_INST;
      bus.compressed = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_LO;
      buf_v      <= 1'b0;
      buf_tag    <= 30'd0;
      buf_data   <= 32'd0;
      drain_addr <= 30'd0;
    end else begin
      state <= state_n;
      if (buf_ld) begin
        buf_v    <= 1'b1;
        buf_tag  <= buf_tag_n;
        buf_data <= buf_data_n;
      end
      if (drain_ld) drain_addr <= bus.ICACHE_addr;
    end
  end

`ifdef REALIGN_RVC_EN
  always_ff @(posedge clk) begin
    if (!rst_n)     hi_r <= 32'd0;
    else if (hi_ld) hi_r <= bus.ICACHE_rdata;
  end
`endif
endmodule

// File: tb/tb_fetch_realigner.sv
// Bench for fetch_realigner: cache model with programmable latency and a reference realigner scoreboard.
module tb_fetch_realigner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_realigner_if bus();
  fetch_realigner dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] mem [16];
  int cache_lat = 0;
  int cnt = 0;
  int reads = 0;
  logic [32:0] sb [$];
  int tests_run = 0;
  int tests_failed = 0;

  assign bus.ICACHE_stall = bus.ICACHE_ren && (cnt < cache_lat);
  assign bus.ICACHE_rdata = bus.ICACHE_stall ? 32'hDEADBEEF : mem[bus.ICACHE_addr[3:0]];

  always @(posedge clk) begin
    if (rst_n && bus.ICACHE_ren) begin
      if (cnt < cache_lat) cnt <= cnt + 1;
      else begin
        cnt   <= 0;
        reads <= reads + 1;
      end
    end
  end

  // Reference: {compressed, inst} straight from memory, no buffering.
  function automatic logic [32:0] model(input logic [31:0] p);
    logic [31:0] lo;
`ifdef REALIGN_RVC_EN
    logic [31:0] hi;
    logic [15:0] h;
`endif
    lo = mem[p[5:2]];
`ifdef REALIGN_RVC_EN
    hi = mem[p[5:2] + 4'd1];
    h  = p[1] ? lo[31:16] : lo[15:0];
    if (h[1:0] != 2'b11) return {1'b1, 16'h0, h};
    if (p[1]) return {1'b0, hi[15:0], lo[31:16]};
`endif
    return {1'b0, lo};
  endfunction

  // Present pc from a negedge, wait for ready, optionally hold with stall=1, consume.
  task automatic drive(input logic [31:0] p, input int hold, output bit got, output int lat,
                       output logic [31:0] o_inst, output logic o_c, output logic o_ren,
                       output logic [29:0] o_addr, output int hold_bad);
    bus.pc = p; bus.stall = 1'b0; got = 0; lat = 0; hold_bad = 0;
    #1;
    o_ren = bus.ICACHE_ren; o_addr = bus.ICACHE_addr;
    while (!got && lat < 60) begin
      if (bus.ready === 1'b1) got = 1;
      else begin lat++; @(negedge clk); #1; end
    end
    o_inst = bus.inst; o_c = bus.compressed;
    if (got && hold > 0) begin
      bus.stall = 1'b1;
      repeat (hold) begin
        @(negedge clk); #1;
        if (bus.ready !== 1'b1 || bus.inst !== o_inst || bus.ICACHE_ren !== 1'b0) hold_bad++;
      end
      bus.stall = 1'b0;
    end
    @(negedge clk);
  endtask

  bit got; int lat, hb, r0;
  logic [31:0] oi; logic oc, oren; logic [29:0] oaddr; logic [32:0] exp_v;

  task automatic test_reset();
    rst_n = 1'b0; bus.pc = 32'd0; bus.stall = 1'b0; bus.redirect = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (bus.ready !== 1'b0 || bus.ICACHE_ren !== 1'b0 || bus.compressed !== 1'b0 || bus.inst !== 32'h13) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ready=%b ren=%b c=%b inst=%h want 0 0 0 00000013",
               bus.ready, bus.ICACHE_ren, bus.compressed, bus.inst);
    end
    tests_run++;
    if (bus.ICACHE_wen !== 1'b0 || bus.ICACHE_wdata !== 32'd0) begin
      tests_failed++; $display("FAIL reset_wen: got %b/%h want 0/0", bus.ICACHE_wen, bus.ICACHE_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_miss();
    int bad;
    bad = 0; cache_lat = 3; mem[0] = 32'h00500093;
    bus.pc = 32'd0; sb.push_back(model(32'd0));
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.ICACHE_ren !== 1'b1 || bus.ICACHE_addr !== 30'd0 || bus.ready !== 1'b0) bad++;
      @(negedge clk);
    end
    #1;
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL miss_req_held: got %0d bad cycles want 0", bad); end
    exp_v = sb.pop_front();
    tests_run++;
    if (bus.ready !== 1'b1 || bus.inst !== exp_v[31:0] || bus.compressed !== exp_v[32]) begin
      tests_failed++;
      $display("FAIL miss_fill: got ready=%b inst=%h c=%b want 1 %h %b", bus.ready, bus.inst, bus.compressed, exp_v[31:0], exp_v[32]);
    end
    @(negedge clk);
    r0 = reads;
    sb.push_back(model(32'd0));
    drive(32'd0, 0, got, lat, oi, oc, oren, oaddr, hb);
    exp_v = sb.pop_front();
    tests_run++;
    if (!got || lat != 0 || oren !== 1'b0 || reads != r0 || oi !== exp_v[31:0]) begin
      tests_failed++;
      $display("FAIL miss_refetch_hit: got got=%0d lat=%0d ren=%b reads+%0d inst=%h want 1 0 0 +0 %h",
               got, lat, oren, reads - r0, oi, exp_v[31:0]);
    end
  endtask

  task automatic test_single_entry();
    cache_lat = 1; mem[1] = 32'h00A00113; r0 = reads;
    sb.push_back(model(32'd4));
    drive(32'd4, 0, got, lat, oi, oc, oren, oaddr, hb);
    exp_v = sb.pop_front();
    tests_run++;
    if (!got || oi !== exp_v[31:0] || oc !== exp_v[32] || lat != 1 || oren !== 1'b1 || oaddr !== 30'd1) begin
      tests_failed++;
      $display("FAIL seq_word1: got inst=%h c=%b lat=%0d ren=%b addr=%0d want %h %b 1 1 1", oi, oc, lat, oren, oaddr, exp_v[31:0], exp_v[32]);
    end
    sb.push_back(model(32'd0));
    drive(32'd0, 0, got, lat, oi, oc, oren, oaddr, hb);
    exp_v = sb.pop_front();
    tests_run++;
    if (!got || oi !== exp_v[31:0] || oren !== 1'b1 || oaddr !== 30'd0 || lat != 1) begin
      tests_failed++;
      $display("FAIL seq_refetch_miss: got inst=%h ren=%b addr=%0d lat=%0d want %h 1 0 1", oi, oren, oaddr, lat, exp_v[31:0]);
    end
    tests_run++;
    if (reads - r0 != 2) begin tests_failed++; $display("FAIL seq_reads: got %0d want 2", reads - r0); end
    sb.push_back(model(32'd0));
    drive(32'd0, 3, got, lat, oi, oc, oren, oaddr, hb);
    exp_v = sb.pop_front();
    tests_run++;
    if (!got || oi !== exp_v[31:0] || hb != 0 || lat != 0) begin
      tests_failed++; $display("FAIL lo_stall_hold: got inst=%h hold_bad=%0d lat=%0d want %h 0 0", oi, hb, lat, exp_v[31:0]);
    end
  endtask

  task automatic test_redirect();
    int bad, drain;
    bad = 0; drain = 0;
    mem[5] = 32'h00000005; mem[12] = 32'h00C00193; cache_lat = 4;
    bus.pc = 32'h14;
    @(negedge clk);
    bus.redirect = 1'b1;
    #1;
    tests_run++;
    if (bus.ready !== 1'b0 || bus.ICACHE_ren !== 1'b1 || bus.ICACHE_addr !== 30'd5) begin
      tests_failed++;
      $display("FAIL redir_cycle: got ready=%b ren=%b addr=%0d want 0 1 5", bus.ready, bus.ICACHE_ren, bus.ICACHE_addr);
    end
    @(negedge clk);
    bus.redirect = 1'b0; bus.pc = 32'h30; sb.push_back(model(32'h30));
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!(bus.ICACHE_ren === 1'b1 && bus.ICACHE_addr === 30'd5)) break;
      if (bus.ready !== 1'b0) bad++;
      drain++;
      @(negedge clk);
    end
    tests_run++;
    if (drain != 3 || bad != 0) begin
      tests_failed++; $display("FAIL redir_drain: got %0d cycles %0d ready want 3 0", drain, bad);
    end
    tests_run++;
    if (bus.ICACHE_ren !== 1'b1 || bus.ICACHE_addr !== 30'd12) begin
      tests_failed++; $display("FAIL redir_newreq: got ren=%b addr=%0d want 1 12", bus.ICACHE_ren, bus.ICACHE_addr);
    end
    lat = 0;
    while (bus.ready !== 1'b1 && lat < 40) begin @(negedge clk); #1; lat++; end
    exp_v = sb.pop_front();
    tests_run++;
    if (bus.ready !== 1'b1 || bus.inst !== exp_v[31:0] || lat != 4) begin
      tests_failed++; $display("FAIL redir_fetch: got ready=%b inst=%h lat=%0d want 1 %h 4", bus.ready, bus.inst, lat, exp_v[31:0]);
    end
    @(negedge clk);
    bus.redirect = 1'b1;
    #1;
    tests_run++;
    if (bus.ready !== 1'b0 || bus.inst !== 32'h13) begin
      tests_failed++; $display("FAIL redir_kill_ready: got ready=%b inst=%h want 0 00000013", bus.ready, bus.inst);
    end
    @(negedge clk);
    bus.redirect = 1'b0;
    #1;
    tests_run++;
    if (bus.ready !== 1'b1 || bus.ICACHE_ren !== 1'b0) begin
      tests_failed++; $display("FAIL redir_resume_hit: got ready=%b ren=%b want 1 0", bus.ready, bus.ICACHE_ren);
    end
    @(negedge clk);
  endtask

`ifdef REALIGN_RVC_EN
  task automatic test_rvc();
    mem[2] = 32'h00014505; cache_lat = 1; r0 = reads;
    sb.push_back(model(32'h8));
    drive(32'h8, 0, got, lat, oi, oc, oren, oaddr, hb);
    exp_v = sb.pop_front();
    tests_run++;
    if (!got || oi !== exp_v[31:0] || oc !== 1'b1 || lat != 1) begin
      tests_failed++; $display("FAIL rvc_lo: got inst=%h c=%b lat=%0d want %h 1 1", oi, oc, lat, exp_v[31:0]);
    end
    sb.push_back(model(32'hA));
    drive(32'hA, 0, got, lat, oi, oc, oren, oaddr, hb);
    exp_v = sb.pop_front();
    tests_run++;
    if (!got || oi !== exp_v[31:0] || oc !== 1'b1 || lat != 0 || reads - r0 != 1) begin
      tests_failed++;
      $display("FAIL rvc_hi: got inst=%h c=%b lat=%0d reads+%0d want %h 1 0 +1", oi, oc, lat, reads - r0, exp_v[31:0]);
    end
  endtask

  task automatic test_straddle();
    mem[6] = 32'h00934505; mem[7] = 32'h00000050; cache_lat = 1;
    sb.push_back(model(32'h1A));
    drive(32'h1A, 0, got, lat, oi, oc, oren, oaddr, hb);
    exp_v = sb.pop_front();
    tests_run++;
    if (!got || oi !== exp_v[31:0] || oc !== 1'b0 || lat != 3) begin
      tests_failed++; $display("FAIL straddle_miss: got inst=%h c=%b lat=%0d want %h 0 3", oi, oc, lat, exp_v[31:0]);
    end
    r0 = reads;
    sb.push_back(model(32'h1C));
    drive(32'h1C, 0, got, lat, oi, oc, oren, oaddr, hb);
    exp_v = sb.pop_front();
    tests_run++;
    if (!got || oi !== exp_v[31:0] || oc !== exp_v[32] || lat != 0 || reads != r0) begin
      tests_failed++; $display("FAIL straddle_buf_w1: got inst=%h c=%b lat=%0d want %h %b 0", oi, oc, lat, exp_v[31:0], exp_v[32]);
    end
    cache_lat = 0;
    sb.push_back(model(32'h18));
    drive(32'h18, 0, got, lat, oi, oc, oren, oaddr, hb);
    exp_v = sb.pop_front();
    sb.push_back(model(32'h1A));
    drive(32'h1A, 0, got, lat, oi, oc, oren, oaddr, hb);
    exp_v = sb.pop_front();
    tests_run++;
    if (!got || oi !== exp_v[31:0] || lat != 1) begin
      tests_failed++; $display("FAIL straddle_hit_lat: got inst=%h lat=%0d want %h 1", oi, lat, exp_v[31:0]);
    end
  endtask

  task automatic test_stall_rdy();
    mem[8] = 32'h00934505; mem[9] = 32'h00000050; cache_lat = 1;
    sb.push_back(model(32'h22));
    drive(32'h22, 3, got, lat, oi, oc, oren, oaddr, hb);
    exp_v = sb.pop_front();
    tests_run++;
    if (!got || oi !== exp_v[31:0] || hb != 0) begin
      tests_failed++; $display("FAIL rdy_hold: got inst=%h hold_bad=%0d want %h 0", oi, hb, exp_v[31:0]);
    end
    r0 = reads;
    sb.push_back(model(32'h24));
    drive(32'h24, 0, got, lat, oi, oc, oren, oaddr, hb);
    exp_v = sb.pop_front();
    tests_run++;
    if (!got || oi !== exp_v[31:0] || lat != 0 || oren !== 1'b0 || reads != r0) begin
      tests_failed++; $display("FAIL rdy_buf_update: got inst=%h lat=%0d ren=%b want %h 0 0", oi, lat, oren, exp_v[31:0]);
    end
  endtask
`else
  task automatic test_no_rvc();
    sb.push_back(model(32'h32));
    drive(32'h32, 0, got, lat, oi, oc, oren, oaddr, hb);
    exp_v = sb.pop_front();
    tests_run++;
    if (!got || oi !== exp_v[31:0] || oc !== 1'b0 || lat != 0) begin
      tests_failed++; $display("FAIL norvc_pc1: got inst=%h c=%b lat=%0d want %h 0 0", oi, oc, lat, exp_v[31:0]);
    end
    mem[3] = 32'h00014505; cache_lat = 1;
    sb.push_back(model(32'hC));
    drive(32'hC, 0, got, lat, oi, oc, oren, oaddr, hb);
    exp_v = sb.pop_front();
    tests_run++;
    if (!got || oi !== exp_v[31:0] || oc !== 1'b0 || lat != 1) begin
      tests_failed++; $display("FAIL norvc_word: got inst=%h c=%b lat=%0d want %h 0 1", oi, oc, lat, exp_v[31:0]);
    end
  endtask
`endif

  initial begin
    foreach (mem[i]) mem[i] = 32'h00000013;
    bus.pc = 32'd0; bus.stall = 1'b0; bus.redirect = 1'b0;
    test_reset();
    test_miss();
    test_single_entry();
    test_redirect();
`ifdef REALIGN_RVC_EN
    test_rvc();
    test_straddle();
    test_stall_rdy();
`else
    test_no_rvc();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/fetch_realigner.md
Name: fetch_realigner

Overview:
- Sits between the IF stage PC logic and the instruction cache.
- Converts the IF PC, which is halfword aligned, into word reads on the 30-bit ICACHE interface.
- Keeps a one-word line buffer so that sequential fetches and RVC fetches reuse data already read.
- Assembles 32-bit instructions that straddle two words and reports `ready`/`compressed`/`inst` to IF.

Parameters:
- NOP_INST, 32'h00000013, value driven on inst whenever ready=0.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- pc  in  32  current IF PC (pc[0] ignored)
- stall  in  1  IF hold; instruction not consumed this cycle
- redirect  in  1  PC correction; pc changes next cycle regardless of ready
- ready  out  1  inst valid this cycle
- compressed  out  1  inst is 16-bit RVC
- inst  out  32  aligned instruction; RVC as {16'b0, half}
- ICACHE_stall  in  1  cache busy; rdata valid when ren=1 and ICACHE_stall=0
- ICACHE_ren  out  1  read request
- ICACHE_wen  out  1  tied 0
- ICACHE_addr  out  30  word address
- ICACHE_rdata  in  32  read data
- ICACHE_wdata  out  32  tied 0

Behaviour:
- Derived signals:
  - W0 = pc[31:2]; W1 = W0+1 (30-bit wrap, 3FFFFFFF+1 = 0).
  - buf_v/buf_tag[29:0]/buf_data[31:0] form the line buffer.
  - lo_hit = buf_v && buf_tag==W0.
  - lo_fill = ren && addr==W0 && !ICACHE_stall.
  - lo_word = lo_hit ? buf_data : ICACHE_rdata.
  - half = pc[1] ? lo_word[31:16] : lo_word[15:0].
  - is_rvc = half[1:0]!=2'b11.
  - straddle = pc[1] && !is_rvc.
- FSM states: S_LO, S_HI, S_RDY, S_DRAIN. Reset: state=S_LO, buf_v=0, hi_r=0.
- While rst_n=0, outputs are: ren=0, ready=0, inst=NOP_INST, compressed=0.
- S_LO:
  - ren = !lo_hit, addr = W0.
  - lo_fill loads buf ← (W0, rdata).
  - If (lo_hit||lo_fill) && !straddle: ready=1, inst = pc[1]||is_rvc ? {16'b0,half} : lo_word, compressed = is_rvc. Stay in S_LO.
  - If (lo_hit||lo_fill) && straddle: ready=0, go to S_HI.
- S_HI:
  - ren=1, addr=W1.
  - When !ICACHE_stall: ready=1, inst = {rdata[15:0], buf_data[31:16]}, compressed=0.
    - If !stall: buf ← (W1, rdata), go to S_LO.
    - Else: hi_r ← rdata, go to S_RDY.
- S_RDY:
  - ren=0, ready=1, inst = {hi_r[15:0], buf_data[31:16]}.
  - When !stall: buf ← (W1, hi_r), go to S_LO.
- redirect (highest priority):
  - No outstanding access (ren=0, or ICACHE_stall=0 this cycle): next state = S_LO. Any fill completing that cycle still updates buf (tag-checked later). hi_r is discarded. ready is forced to 0.
  - Outstanding access (ren=1 and ICACHE_stall=1): latch drain_addr=addr, go to S_DRAIN.
- S_DRAIN: ren=1, addr=drain_addr, ready=0. When !ICACHE_stall: discard data, go to S_LO. A further redirect in S_DRAIN is absorbed, since the tag compare uses the live pc.
- Request stability: addr and ren stay constant while ICACHE_stall=1. pc is stable in that case because ready=0.
- Latencies:
  - Aligned or RVC instruction with buffer hit: 0 cycles.
  - Buffer miss: cache latency, with bypass.
  - Straddling instruction with cache hits: 1 extra cycle.
- stall=1 with ready=1 in S_LO holds the outputs stable (pure function of pc and buf).

Optional Feature:
- Macro REALIGN_RVC_EN.
- Defined: behaviour as above.
- Undefined: pc[1] treated as 0, is_rvc forced 0, compressed=0. S_HI, S_RDY and hi_r are removed; straddle never occurs.

Test Plan:
- Reset, then pc=0, cache returns 32'h00500093 after 3 stall cycles → ren=1 addr=0 held, then ready=1 inst=00500093 compressed=0 in the fill cycle, buf_tag=0.
- pc=0 then pc=4 with word1 = 32'h00A00113; next pc=0 refetch → pc=4 misses and fills; pc=0 misses again. ren=1 addr=0 proves the single-entry buffer.
- Word0 = 32'h0001_4505 (c.li a0,1 at 0, c.nop at 2), pc=0 then pc=2 → both ready=1 compressed=1, inst=00004505 then 00000001, only one cache read.
- Word0 = 32'h0093_4505, word1 = 32'h0000_0050, pc=2 → S_HI reads addr=1; ready inst=00500093 compressed=0; after consumption buf_tag=1.
- Straddle as above with stall=1 for 3 cycles after hi data → S_RDY holds inst=00500093 ready=1 ren=0; buf updated only on stall=0.
- Redirect while ICACHE_stall=1 on addr=5 → ren=1 addr=5 held until stall drops, data discarded, ready=0, then new pc fetched.
